// File: rtl/fft_sched_ctrl_if.sv
// Control bundle between the FFT sequencer and the datapath it drives.
interface fft_sched_ctrl_if #(
  parameter int unsigned LOG2N = 4
);
  localparam int unsigned TW_BITS = (LOG2N - 1) * (LOG2N - 1);

  logic                 en;
  logic                 start;
  logic                 busy;
  logic [LOG2N-1:0]     stage_en;
  logic [TW_BITS-1:0]   tw_idx;
  logic                 out_valid;
  logic [LOG2N-1:0]     out_idx;
  logic                 finish;

  modport master (
    output en, start,
    input  busy, stage_en, tw_idx, out_valid, out_idx, finish
  );

  modport slave (
    input  en, start,
    output busy, stage_en, tw_idx, out_valid, out_idx, finish
  );
endinterface

// File: rtl/fft_sched_ctrl.sv
// Frame sequencer for a radix-2 DIF SDF FFT: a stallable global cycle counter
// decoded into stage windows, twiddle exponents and output bin indices.
module fft_sched_ctrl #(
  parameter int unsigned LOG2N    = 4,
  parameter int unsigned CNT_BITS = LOG2N + 1
) (
  input  logic               clk,
  input  logic               rst,
  fft_sched_ctrl_if.slave    bus
);
  localparam int unsigned N       = 1 << LOG2N;
  localparam int unsigned TW_W    = LOG2N - 1;
  localparam int unsigned TW_BITS = TW_W * TW_W;
  localparam logic [CNT_BITS-1:0] G_LAST    = CNT_BITS'(2 * N - 2);
  localparam logic [CNT_BITS-1:0] OUT_FIRST = CNT_BITS'(N - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] g_q, g_d;

  logic                run_c;
  logic [LOG2N-1:0]    win_c;
  logic                out_win_c;
  logic [LOG2N-1:0]    stage_en_c;
  logic [TW_BITS-1:0]  tw_idx_c;
  logic                out_valid_c;
  logic [LOG2N-1:0]    out_idx_c;
  logic [LOG2N-1:0]    rel_c;
  logic                finish_c;

  // First-sample offset of stage s (1-based): sum of N>>k for k < s.
  function automatic int unsigned stage_ofs(int unsigned s);
    int unsigned acc;
    acc = 0;
    for (int unsigned k = 1; k < s; k++) acc += N >> k;
    return acc;
  endfunction

  function automatic logic in_win(int unsigned s, logic [CNT_BITS-1:0] g);
    logic [CNT_BITS-1:0] lo;
    lo = CNT_BITS'(stage_ofs(s));
    return (g >= lo) && (g <= lo + CNT_BITS'(N - 1));
  endfunction

  // Twiddle exponent of multiplier j; truncation to TW_W bits is the mod N/2.
  function automatic logic [TW_W-1:0] tw_of(int unsigned j, logic [CNT_BITS-1:0] g);
    logic [CNT_BITS-1:0] c, b, d;
    c = g - CNT_BITS'(stage_ofs(j + 1));
    d = CNT_BITS'(N >> j);
    b = c & ((d << 1) - CNT_BITS'(1));
    if (b < d) return '0;
    return TW_W'((b - d) << (j - 1));
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      g_q     <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    case (state_q)
      IDLE: begin
        if (bus.start && bus.en) begin
          state_d = RUN;
          g_d     = '0;
        end
      end
      RUN: begin
        if (bus.en) begin
          if (g_q == G_LAST) begin
            state_d = IDLE;
            g_d     = '0;
          end else begin
            g_d = g_q + CNT_BITS'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        g_d     = '0;
      end
    endcase
  end

  // Output decode; index outputs use the un-stalled windows so they hold under en=0.
  always_comb begin
    run_c       = (state_q == RUN);
    win_c       = '0;
    tw_idx_c    = '0;
    out_idx_c   = '0;
    rel_c       = LOG2N'(g_q - OUT_FIRST);
    for (int unsigned s = 0; s < LOG2N; s++) begin
      win_c[s] = run_c && in_win(s + 1, g_q);
    end
    for (int unsigned j = 1; j < LOG2N; j++) begin
      if (win_c[j]) tw_idx_c[(j - 1) * TW_W +: TW_W] = tw_of(j, g_q);
    end
    out_win_c = run_c && (g_q >= OUT_FIRST) && (g_q <= G_LAST);
    if (out_win_c) begin
      for (int unsigned i = 0; i < LOG2N; i++) out_idx_c[i] = rel_c[LOG2N - 1 - i];
    end
    stage_en_c  = win_c & {LOG2N{bus.en}};
    out_valid_c = out_win_c && bus.en;
    finish_c    = out_valid_c && (g_q == G_LAST);
  end

  assign bus.busy      = run_c;
  assign bus.stage_en  = stage_en_c;
  assign bus.tw_idx    = tw_idx_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_idx   = out_idx_c;
  assign bus.finish    = finish_c;

endmodule

// File: tb/tb_fft_sched_ctrl.sv
// Scoreboard bench for fft_sched_ctrl (N=16): per-cycle expected vectors from
// hand-written sequence tables, plus an output-stream queue popped on out_valid.
module tb_fft_sched_ctrl;
  typedef struct packed {
    logic       busy;
    logic [3:0] stage_en;
    logic [8:0] tw;
    logic       ov;
    logic [3:0] oi;
    logic       fin;
  } out_t;

  typedef struct packed {
    logic [3:0] oi;
    logic       fin;
  } strm_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fft_sched_ctrl_if #(.LOG2N(4)) bus ();
  fft_sched_ctrl #(.LOG2N(4), .CNT_BITS(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  out_t  qexp[$];
  int    qid[$];
  strm_t sq[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc_n = 0;
  bit    erun = 1'b0;
  int    eg = 0;

  // Expected outputs for model state (run, g) and current en, from literal tables.
  function automatic out_t exp_of(bit run, int g, bit e);
    out_t o;
    int lo[4] = '{0, 8, 12, 14};
    int t2[8] = '{0, 0, 0, 0, 0, 2, 4, 6};
    int t3[4] = '{0, 0, 0, 4};
    int oi[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    o = '0;
    if (!run) return o;
    o.busy = 1'b1;
    for (int s = 0; s < 4; s++)
      if (g >= lo[s] && g <= lo[s] + 15) o.stage_en[s] = e;
    if (g >= 16 && g <= 23) o.tw[2:0] = 3'(g - 16);
    if (g >= 12 && g <= 27) o.tw[5:3] = 3'(t2[(g - 12) % 8]);
    if (g >= 14 && g <= 29) o.tw[8:6] = 3'(t3[(g - 14) % 4]);
    if (g >= 15 && g <= 30) begin
      o.ov  = e;
      o.oi  = 4'(oi[g - 15]);
      o.fin = e && (g == 30);
    end
    return o;
  endfunction

  // One clock cycle: drive at negedge, queue expectation, advance model at posedge.
  task automatic cyc(input logic r, input logic s, input logic e);
    @(negedge clk);
    rst       = r;
    bus.start = s;
    bus.en    = e;
    if (!r) begin
      erun = 1'b0;
      eg   = 0;
      sq.delete();
    end
    qexp.push_back(exp_of(erun, eg, e));
    qid.push_back(cyc_n);
    cyc_n++;
    @(posedge clk);
    if (r) begin
      if (!erun) begin
        if (s && e) begin
          erun = 1'b1;
          eg   = 0;
          for (int k = 0; k < 16; k++) begin
            strm_t t;
            t.oi  = 4'({k[0], k[1], k[2], k[3]});
            t.fin = (k == 15);
            sq.push_back(t);
          end
        end
      end else if (e) begin
        if (eg == 30) begin
          erun = 1'b0;
          eg   = 0;
        end else begin
          eg++;
        end
      end
    end
  endtask

  task automatic run_frame(input int stall_at, input int stall_len,
                           input int start_at, input int rst_at);
    int guard;
    int stalls;
    guard  = 0;
    stalls = 0;
    cyc(1'b1, 1'b1, 1'b1);
    while (erun && guard < 100) begin
      guard++;
      if (eg == stall_at && stalls < stall_len) begin
        stalls++;
        cyc(1'b1, 1'b0, 1'b0);
      end else if (eg == rst_at) begin
        cyc(1'b0, 1'b0, 1'b1);
      end else begin
        cyc(1'b1, logic'(eg == start_at), 1'b1);
      end
    end
    if (erun) begin
      failures++;
      $display("FAIL frame_timeout: model still running after %0d cycles, required idle", guard);
    end
    repeat (2) cyc(1'b1, 1'b0, 1'b1);
  endtask

  // Per-cycle monitor: compares the whole output vector mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (qexp.size() > 0) begin
        out_t e;
        out_t a;
        int   id;
        e  = qexp.pop_front();
        id = qid.pop_front();
        a  = {bus.busy, bus.stage_en, bus.tw_idx, bus.out_valid, bus.out_idx, bus.finish};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL cyc%0d: got busy=%b se=%b tw=%h ov=%b oi=%0d fin=%b, expected busy=%b se=%b tw=%h ov=%b oi=%0d fin=%b",
                   id, a.busy, a.stage_en, a.tw, a.ov, a.oi, a.fin,
                   e.busy, e.stage_en, e.tw, e.ov, e.oi, e.fin);
        end
      end
    end
  end

  // Stream monitor: pops one expected bin whenever the DUT presents out_valid.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (bus.out_valid === 1'b1) begin
        checks++;
        if (sq.size() == 0) begin
          failures++;
          $display("FAIL stream_extra: got out_idx=%0d with no sample expected", bus.out_idx);
        end else begin
          strm_t t;
          t = sq.pop_front();
          if (bus.out_idx !== t.oi || bus.finish !== t.fin) begin
            failures++;
            $display("FAIL stream: got idx=%0d fin=%b, expected idx=%0d fin=%b",
                     bus.out_idx, bus.finish, t.oi, t.fin);
          end
        end
      end
    end
  end

  initial begin
    bus.en    = 1'b1;
    bus.start = 1'b0;
    // Reset held, then idle with start low.
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
    repeat (10) cyc(1'b1, 1'b0, 1'b1);
    // Nominal frame.
    run_frame(-1, 0, -1, -1);
    // Five-cycle stall at g=10.
    run_frame(10, 5, -1, -1);
    // Start pulse inside the frame is ignored.
    run_frame(-1, 0, 20, -1);
    // Reset abort at g=18, then a clean frame.
    run_frame(-1, 0, -1, 18);
    run_frame(-1, 0, -1, -1);
    // Start with en low is lost; reset beats a simultaneous start.
    repeat (3) cyc(1'b1, 1'b1, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    repeat (3) cyc(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    #4;
    checks++;
    if (qexp.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending vectors, expected 0", qexp.size());
    end
    checks++;
    if (sq.size() != 0) begin
      failures++;
      $display("FAIL stream_left: got %0d outputs never produced, expected 0", sq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
